// File: rtl/aplic_domain_notifier.sv
// APLIC domain notifier: sweeps the gateway's pending bitmap one source per cycle and
// presents the best pending, enabled source as topi/irq, pulsing claimed back on a claim.
`timescale 1ns/1ps

module aplic_domain_notifier #(
    parameter int NR_SRC      = 32,
    parameter int NR_BITS_SRC = (NR_SRC > 32) ? 32 : NR_SRC,
    parameter int NR_REG      = (NR_SRC - 1) / 32,
    parameter int IPRIOLEN    = 3
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [(NR_REG+1)*NR_BITS_SRC-1:0] i_intp_pen,
    input  logic [(NR_REG+1)*NR_BITS_SRC-1:0] i_enable,
    input  logic [NR_SRC*IPRIOLEN-1:0]        i_target_prio,
    input  logic                              i_domaincfgIE,
    input  logic                              i_idelivery,
    input  logic [IPRIOLEN-1:0]               i_ithreshold,
    input  logic                              i_claim,
    output logic [31:0]                       o_topi,
    output logic                              o_irq,
    output logic [(NR_REG+1)*NR_BITS_SRC-1:0] o_claimed
);

    localparam int W   = (NR_REG + 1) * NR_BITS_SRC;
    localparam int IDW = (NR_SRC > 2) ? $clog2(NR_SRC) : 1;
    localparam logic [IDW-1:0] FIRST_IDX = IDW'(1);
    localparam logic [IDW-1:0] LAST_IDX  = IDW'(NR_SRC - 1);

    typedef enum logic [1:0] {IDLE, SCAN, CLAIM} state_t;

    state_t              state, state_next;
    logic [IDW-1:0]      idx, idx_next;
    logic [IDW-1:0]      best_id, best_id_next;
    logic [IPRIOLEN-1:0] best_prio, best_prio_next;
    logic [31:0]         topi_next;
    logic                irq_next;
    logic [W-1:0]        claimed_next;
    logic [W-1:0]        claim_mask;

    logic [IPRIOLEN-1:0] cand_prio;
    logic                cand_ok;
    logic                cand_wins;
    logic [IDW-1:0]      fin_id;
    logic [IPRIOLEN-1:0] fin_prio;
    logic [9:0]          claim_id;

    // Source under inspection this cycle; a zero threshold disables the threshold test.
    assign cand_prio = i_target_prio[idx*IPRIOLEN +: IPRIOLEN];
    assign cand_ok   = (idx != '0) && i_intp_pen[idx] && i_enable[idx] && (cand_prio != '0)
                       && ((i_ithreshold == '0) || (cand_prio < i_ithreshold));
    assign cand_wins = cand_ok && ((best_id == '0) || (cand_prio < best_prio));
    assign fin_id    = cand_wins ? idx : best_id;
    assign fin_prio  = cand_wins ? cand_prio : best_prio;
    assign claim_id  = o_topi[25:16];

    always_comb begin
        claim_mask = '0;
        for (int i = 1; i < W; i++) begin
            if (i < NR_SRC) claim_mask[i] = (claim_id == 10'(i));
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        state_next     = state;
        idx_next       = idx;
        best_id_next   = best_id;
        best_prio_next = best_prio;
        topi_next      = o_topi;
        irq_next       = o_irq;
        claimed_next   = '0;

        if (!(i_domaincfgIE && i_idelivery)) begin
            state_next     = IDLE;
            idx_next       = FIRST_IDX;
            best_id_next   = '0;
            best_prio_next = '0;
            topi_next      = '0;
            irq_next       = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_next     = SCAN;
                    idx_next       = FIRST_IDX;
                    best_id_next   = '0;
                    best_prio_next = '0;
                end
                SCAN: begin
                    if (i_claim && (o_topi != '0)) begin
                        state_next     = CLAIM;
                        claimed_next   = claim_mask;
                        topi_next      = '0;
                        irq_next       = 1'b0;
                        idx_next       = FIRST_IDX;
                        best_id_next   = '0;
                        best_prio_next = '0;
                    end else if (idx == LAST_IDX) begin
                        // End of sweep: publish the winner and start over from source 1.
                        topi_next                 = '0;
                        topi_next[25:16]          = 10'(fin_id);
                        topi_next[IPRIOLEN-1:0]   = fin_prio;
                        irq_next                  = (fin_id != '0);
                        idx_next                  = FIRST_IDX;
                        best_id_next              = '0;
                        best_prio_next            = '0;
                    end else begin
                        idx_next       = idx + FIRST_IDX;
                        best_id_next   = fin_id;
                        best_prio_next = fin_prio;
                    end
                end
                CLAIM: begin
                    state_next = SCAN;
                    idx_next   = FIRST_IDX;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            idx       <= '0;
            best_id   <= '0;
            best_prio <= '0;
            o_topi    <= '0;
            o_irq     <= 1'b0;
            o_claimed <= '0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            best_id   <= best_id_next;
            best_prio <= best_prio_next;
            o_topi    <= topi_next;
            o_irq     <= irq_next;
            o_claimed <= claimed_next;
        end
    end

endmodule

// File: tb/tb_aplic_domain_notifier.sv
// Self-checking bench for aplic_domain_notifier: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a sweep-level model.
`timescale 1ns/1ps

module tb_aplic_domain_notifier;

    localparam int NR_SRC   = 32;
    localparam int IPRIOLEN = 3;
    localparam int W        = 32;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic [W-1:0]               intp_pen = '0;
    logic [W-1:0]               enable = '0;
    logic [NR_SRC*IPRIOLEN-1:0] target_prio = '0;
    logic                       domaincfg_ie = 1'b0;
    logic                       idelivery = 1'b0;
    logic [IPRIOLEN-1:0]        ithreshold = '0;
    logic                       claim = 1'b0;
    logic [31:0]                topi;
    logic                       irq;
    logic [W-1:0]               claimed;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    aplic_domain_notifier #(.NR_SRC(NR_SRC), .IPRIOLEN(IPRIOLEN)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_intp_pen    (intp_pen),
        .i_enable      (enable),
        .i_target_prio (target_prio),
        .i_domaincfgIE (domaincfg_ie),
        .i_idelivery   (idelivery),
        .i_ithreshold  (ithreshold),
        .i_claim       (claim),
        .o_topi        (topi),
        .o_irq         (irq),
        .o_claimed     (claimed)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A sweep visits source n on its n-th scan cycle; the commit publishes the lowest
    // priority value among sources found eligible on their visit, first id on ties.
    typedef struct {int id; int prio;} cand_t;
    cand_t       cands[$];
    bit          active = 1'b0;
    bit          in_claim = 1'b0;
    int          pos = 1;
    logic [31:0] exp_topi = '0;
    logic        exp_irq = 1'b0;
    logic [W-1:0] exp_claimed = '0;

    function automatic int prio_of(input int n);
        return int'(target_prio[n*IPRIOLEN +: IPRIOLEN]);
    endfunction

    function automatic bit eligible(input int n);
        int p = prio_of(n);
        if (n == 0 || n >= NR_SRC) return 1'b0;
        if (!(intp_pen[n] && enable[n])) return 1'b0;
        if (p == 0) return 1'b0;
        if (ithreshold != 0 && p >= int'(ithreshold)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] pick();
        int bid = 0;
        int bp  = 0;
        foreach (cands[k]) begin
            if (bid == 0 || cands[k].prio < bp) begin
                bid = cands[k].id;
                bp  = cands[k].prio;
            end
        end
        return (32'(bid) << 16) | 32'(bp);
    endfunction

    always @(posedge clk or posedge rst) begin
        exp_claimed <= '0;
        if (rst) begin
            active <= 1'b0; in_claim <= 1'b0; pos <= 1; cands.delete();
            exp_topi <= '0; exp_irq <= 1'b0;
        end else if (!(domaincfg_ie && idelivery)) begin
            active <= 1'b0; in_claim <= 1'b0; pos <= 1; cands.delete();
            exp_topi <= '0; exp_irq <= 1'b0;
        end else if (!active) begin
            active <= 1'b1; pos <= 1; cands.delete();
        end else if (in_claim) begin
            in_claim <= 1'b0; pos <= 1; cands.delete();
        end else if (claim && exp_topi != 0) begin
            in_claim    <= 1'b1;
            exp_claimed <= 32'(1) << exp_topi[25:16];
            exp_topi    <= '0;
            exp_irq     <= 1'b0;
            pos         <= 1;
            cands.delete();
        end else begin
            if (eligible(pos)) cands.push_back('{id: pos, prio: prio_of(pos)});
            if (pos == NR_SRC - 1) begin
                exp_topi <= pick();
                exp_irq  <= (cands.size() != 0);
                cands.delete();
                pos <= 1;
            end else begin
                pos <= pos + 1;
            end
        end
    end

    always @(negedge clk) begin
        check("topi_vs_model", topi, exp_topi);
        check("irq_vs_model", {31'b0, irq}, {31'b0, exp_irq});
        check("claimed_vs_model", claimed, exp_claimed);
    end

    // ---------------- stimulus ----------------
    task automatic set_prio(input int n, input int p);
        target_prio[n*IPRIOLEN +: IPRIOLEN] = IPRIOLEN'(p);
    endtask

    task automatic wait_topi(input string name, input logic [31:0] want, input int budget);
        int n = 0;
        while (topi !== want && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, topi, want);
    endtask

    initial begin
        rst = 1'b1;
        domaincfg_ie = 1'b1;
        idelivery = 1'b1;
        enable = '1;
        intp_pen = (32'(1) << 5) | (32'(1) << 9);
        set_prio(5, 3);
        set_prio(9, 2);
        repeat (2) @(negedge clk);
        check("reset_topi", topi, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        check("reset_claimed", claimed, 32'h0);
        rst = 1'b0;

        // Best of two: source 9 with prio 2 beats source 5 with prio 3.
        wait_topi("best_of_two", 32'h0009_0002, 40);
        check("best_irq", {31'b0, irq}, 32'h1);

        // Claim source 9, gateway clears its pending bit.
        claim = 1'b1;
        @(negedge clk);
        claim = 1'b0;
        check("claim_pulse", claimed, 32'h0000_0200);
        check("claim_topi_cleared", topi, 32'h0);
        check("claim_irq_cleared", {31'b0, irq}, 32'h0);
        intp_pen[9] = 1'b0;
        @(negedge clk);
        check("claim_pulse_one_cycle", claimed, 32'h0);
        wait_topi("after_claim", 32'h0005_0003, 40);

        // Equal priorities: lower id wins.
        intp_pen = (32'(1) << 4) | (32'(1) << 7);
        set_prio(4, 2);
        set_prio(7, 2);
        wait_topi("tie_low_id", 32'h0004_0002, 70);

        // Threshold excludes prio >= threshold.
        intp_pen = 32'(1) << 3;
        set_prio(3, 2);
        ithreshold = 3'd2;
        repeat (70) @(negedge clk);
        check("threshold_blocks", topi, 32'h0);
        check("threshold_no_irq", {31'b0, irq}, 32'h0);
        ithreshold = 3'd3;
        wait_topi("threshold_passes", 32'h0003_0002, 70);
        check("threshold_irq", {31'b0, irq}, 32'h1);

        // Disable the domain mid-sweep, then claim while idle.
        repeat (7) @(negedge clk);
        domaincfg_ie = 1'b0;
        @(negedge clk);
        check("ie_drop_topi", topi, 32'h0);
        check("ie_drop_irq", {31'b0, irq}, 32'h0);
        claim = 1'b1;
        @(negedge clk);
        claim = 1'b0;
        check("idle_claim_none", claimed, 32'h0);
        @(negedge clk);
        check("idle_claim_none2", claimed, 32'h0);
        domaincfg_ie = 1'b1;
        wait_topi("reenable", 32'h0003_0002, 40);

        // Asynchronous reset in the middle of a sweep.
        repeat (9) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_topi", topi, 32'h0);
        check("async_rst_irq", {31'b0, irq}, 32'h0);
        check("async_rst_claimed", claimed, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        wait_topi("post_reset_commit", 32'h0003_0002, 40);

        // Randomized traffic, gateway clears pending bits it sees claimed.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            intp_pen = intp_pen & ~claimed;
            if ($urandom % 4 == 0) intp_pen[$urandom % 32] = 1'b1;
            if ($urandom % 64 == 0) intp_pen = '0;
            if (i % 400 == 0) enable = $urandom | $urandom;
            if (i % 150 == 0) target_prio = {$urandom, $urandom, $urandom};
            if (i % 500 == 0) ithreshold = ($urandom % 2 == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            claim = ($urandom % 6 == 0);
            domaincfg_ie = ($urandom % 300 != 0);
            idelivery = ($urandom % 300 != 0);
            rst = ($urandom % 1500 == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        claim = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
